// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, opcode-class encodings, funct7 constants.
package alu_pkg;

    // ALU control codes; 1010-1111 are unused
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Opcode class from the main decoder
    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    // funct7 values
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // funct3 encodings of the integer ALU group
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: (alu_op, funct3, funct7) -> (control, illegal).
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] control,
    output logic       illegal
);

    logic [3:0] code;
    logic       bad;
    logic       is_rtype;
    logic       alt;
    logic       shift_alt;

    assign is_rtype  = (alu_op == ALU_OP_RTYPE);
    assign alt       = (funct7 == FUNCT7_ALT);
    // I-type shifts carry a 6-bit shamt in funct7[0], so only bit 5 selects SRA
    assign shift_alt = is_rtype ? alt : funct7[5];

    // Map fields to a control code and flag combinations the ALU cannot execute
    always_comb begin
        code = ALU_ADD;
        bad  = 1'b0;
        case (alu_op)
            ALU_OP_MEM:    code = ALU_ADD;
            ALU_OP_BRANCH: code = ALU_SUB;
            default: begin
                case (funct3)
                    F3_ADD:  code = (is_rtype && alt) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  code = ALU_SLL;
                    F3_SLT:  code = ALU_SLT;
                    F3_SLTU: code = ALU_SLTU;
                    F3_XOR:  code = ALU_XOR;
                    F3_SR:   code = shift_alt ? ALU_SRA : ALU_SRL;
                    F3_OR:   code = ALU_OR;
                    default: code = ALU_AND;
                endcase
                if (is_rtype) begin
                    bad = ((funct7 != FUNCT7_BASE) && !alt) ||
                          (alt && (funct3 != F3_ADD) && (funct3 != F3_SR));
                end else begin
                    bad = ((funct3 == F3_SLL) || (funct3 == F3_SR)) &&
                          (funct7[6] || (funct7[4:1] != 4'b0000));
                end
            end
        endcase
        control = bad ? ALU_ADD : code;
        illegal = bad;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: decodes control, selects operand B and presents
// the bundle through a 2-entry skid buffer (main M, skid S) with a flopped in_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_alu_op,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic             in_alu_src,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [3:0]       out_control,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [3:0]       dec_control;
    logic             dec_illegal;
    logic [XLEN-1:0]  sel_b;

    logic             m_valid;
    logic [XLEN-1:0]  m_a;
    logic [XLEN-1:0]  m_b;
    logic [3:0]       m_control;
    logic             m_illegal;
    logic [TAG_W-1:0] m_tag;

    logic             s_valid;
    logic [XLEN-1:0]  s_a;
    logic [XLEN-1:0]  s_b;
    logic [3:0]       s_control;
    logic             s_illegal;
    logic [TAG_W-1:0] s_tag;

    logic             in_ready_q;
    logic             accept;
    logic             xfer;
    logic             ld_m_in;
    logic             ld_m_s;
    logic             ld_s;
    logic             m_valid_nx;
    logic             s_valid_nx;

    alu_ctrl_decode u_decode (
        .alu_op  (in_alu_op),
        .funct3  (in_funct3),
        .funct7  (in_funct7),
        .control (dec_control),
        .illegal (dec_illegal)
    );

    assign sel_b  = in_alu_src ? in_imm : in_rs2;
    assign accept = in_valid & in_ready_q;
    assign xfer   = m_valid & out_ready;

    // Decide where an accepted beat lands and whether S refills M
    always_comb begin
        ld_m_in    = 1'b0;
        ld_m_s     = 1'b0;
        ld_s       = 1'b0;
        m_valid_nx = m_valid;
        s_valid_nx = s_valid;
        if (s_valid) begin
            // in_ready is low whenever S is full, so no accept can occur here
            if (xfer) begin
                ld_m_s     = 1'b1;
                s_valid_nx = 1'b0;
            end
        end else if (!m_valid || xfer) begin
            ld_m_in    = accept;
            m_valid_nx = accept;
        end else if (accept) begin
            ld_s       = 1'b1;
            s_valid_nx = 1'b1;
        end
    end

    // Valid bits and the registered in_ready; reset beats flush, flush beats handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid    <= m_valid_nx;
            s_valid    <= s_valid_nx;
            in_ready_q <= !s_valid_nx;
        end
    end

    // Main data register: loads from the input or from S, never cleared by flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_a       <= '0;
            m_b       <= '0;
            m_control <= ALU_ADD;
            m_illegal <= 1'b0;
            m_tag     <= '0;
        end else if (!flush) begin
            if (ld_m_s) begin
                m_a       <= s_a;
                m_b       <= s_b;
                m_control <= s_control;
                m_illegal <= s_illegal;
                m_tag     <= s_tag;
            end else if (ld_m_in) begin
                m_a       <= in_rs1;
                m_b       <= sel_b;
                m_control <= dec_control;
                m_illegal <= dec_illegal;
                m_tag     <= in_tag;
            end
        end
    end

    // Skid data register: holds the beat accepted while M is stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_a       <= '0;
            s_b       <= '0;
            s_control <= ALU_ADD;
            s_illegal <= 1'b0;
            s_tag     <= '0;
        end else if (!flush && ld_s) begin
            s_a       <= in_rs1;
            s_b       <= sel_b;
            s_control <= dec_control;
            s_illegal <= dec_illegal;
            s_tag     <= in_tag;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid;
    assign out_a       = m_a;
    assign out_b       = m_b;
    assign out_control = m_control;
    assign out_illegal = m_illegal;
    assign out_tag     = m_tag;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: decode table, directed handshake
// sequences and random traffic against a queue-based reference model.
module tb_alu_issue_stage;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_alu_op;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic             in_alu_src;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_imm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_a;
    logic [XLEN-1:0]  out_b;
    logic [3:0]       out_control;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    alu_issue_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_op   (in_alu_op),
        .in_funct3   (in_funct3),
        .in_funct7   (in_funct7),
        .in_alu_src  (in_alu_src),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_control (out_control),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [3:0]       ctrl;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } beat_t;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] ctrl;
        logic       ill;
    } dvec_t;

    beat_t q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference decode: base operation per funct3, then the alternate-form
    // substitutions, then legality; illegal beats fall back to ADD.
    function automatic void ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, output logic [3:0] c,
                                       output logic il);
        logic [3:0] base_tbl [0:7];
        logic       r;
        logic       i;
        base_tbl = '{4'd2, 4'd5, 4'd8, 4'd9, 4'd4, 4'd3, 4'd1, 4'd0};
        r  = (op == 2'd2);
        i  = (op == 2'd3);
        il = 1'b0;
        if (op == 2'd0)      c = 4'd2;
        else if (op == 2'd1) c = 4'd6;
        else begin
            c = base_tbl[f3];
            if (r && f7 == 7'h20 && f3 == 3'd0) c = 4'd6;
            if (f3 == 3'd5 && ((r && f7 == 7'h20) || (i && f7[5]))) c = 4'd7;
        end
        if (r) il = !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
        if (i) il = (f3 == 3'd1 || f3 == 3'd5) && ((f7 & 7'b1011110) != 7'd0);
        if (il) c = 4'd2;
    endfunction

    task automatic set_beat(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic src, input logic [63:0] rs1, input logic [63:0] rs2,
                            input logic [63:0] imm, input logic [TAG_W-1:0] tag);
        in_alu_op  = op;
        in_funct3  = f3;
        in_funct7  = f7;
        in_alu_src = src;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_tag     = tag;
    endtask

    // One clock: predict handshakes from current inputs, advance model, check at negedge
    task automatic cycle();
        logic  acc;
        logic  xfr;
        beat_t nb;
        logic [3:0] c;
        logic  il;
        acc = (in_valid === 1'b1) && (in_ready === 1'b1);
        xfr = (out_valid === 1'b1) && (out_ready === 1'b1);
        ref_decode(in_alu_op, in_funct3, in_funct7, c, il);
        nb.a    = in_rs1;
        nb.b    = in_alu_src ? in_imm : in_rs2;
        nb.ctrl = c;
        nb.ill  = il;
        nb.tag  = in_tag;
        @(posedge clk);
        if (!rst_n || flush) q.delete();
        else begin
            if (xfr && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(nb);
        end
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0 && out_valid === 1'b1) begin
            chk("out_a", out_a, q[0].a);
            chk("out_b", out_b, q[0].b);
            chk("out_control", 64'(out_control), 64'(q[0].ctrl));
            chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
    endtask

    // Stall the output and accept exactly two beats so M and S are both full
    task automatic fill(input logic [TAG_W-1:0] t0);
        int   k;
        logic pre;
        k         = 0;
        out_ready = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 6 && k < 2; i++) begin
            in_valid = 1'b1;
            set_beat(2'd2, 3'd0, 7'h00, 1'b0, 64'(k + 100), 64'(k + 200), 64'd0, t0 + TAG_W'(k));
            pre = (in_ready === 1'b1);
            cycle();
            if (pre) k++;
        end
        in_valid = 1'b0;
        chk("fill_count", 64'(k), 64'd2);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_a"}, out_a, 64'd0);
        chk({pfx, "_b"}, out_b, 64'd0);
        chk({pfx, "_tag"}, 64'(out_tag), 64'd0);
        chk({pfx, "_control"}, 64'(out_control), 64'd2);
        chk({pfx, "_illegal"}, 64'(out_illegal), 64'd0);
        chk({pfx, "_valid"}, 64'(out_valid), 64'd0);
        chk({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        dvec_t dv[9];
        logic [TAG_W-1:0] got[$];
        int    t;
        int    ncyc;
        logic  pre;

        dv[0] = '{op: 2'd2, f3: 3'd0, f7: 7'h20, ctrl: 4'b0110, ill: 1'b0};
        dv[1] = '{op: 2'd2, f3: 3'd5, f7: 7'h20, ctrl: 4'b0111, ill: 1'b0};
        dv[2] = '{op: 2'd3, f3: 3'd0, f7: 7'h20, ctrl: 4'b0010, ill: 1'b0};
        dv[3] = '{op: 2'd2, f3: 3'd1, f7: 7'h20, ctrl: 4'b0010, ill: 1'b1};
        dv[4] = '{op: 2'd1, f3: 3'd3, f7: 7'h00, ctrl: 4'b0110, ill: 1'b0};
        dv[5] = '{op: 2'd3, f3: 3'd5, f7: 7'h20, ctrl: 4'b0111, ill: 1'b0};
        dv[6] = '{op: 2'd2, f3: 3'd0, f7: 7'h01, ctrl: 4'b0010, ill: 1'b1};
        dv[7] = '{op: 2'd3, f3: 3'd1, f7: 7'h40, ctrl: 4'b0010, ill: 1'b1};
        dv[8] = '{op: 2'd3, f3: 3'd5, f7: 7'h01, ctrl: 4'b0011, ill: 1'b0};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_beat(2'd0, 3'd0, 7'd0, 1'b0, 64'd0, 64'd0, 64'd0, '0);
        @(negedge clk);
        cycle();
        cycle();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Decode table
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            set_beat(dv[i].op, dv[i].f3, dv[i].f7, 1'b0, 64'(i), 64'(i * 3), 64'd0, TAG_W'(i));
            cycle();
            chk($sformatf("dec%0d_control", i), 64'(out_control), 64'(dv[i].ctrl));
            chk($sformatf("dec%0d_illegal", i), 64'(out_illegal), 64'(dv[i].ill));
        end

        // Full sweep of alu_op/funct3 with both funct7 forms, streamed back-to-back
        for (int op = 0; op < 4; op++)
            for (int f3 = 0; f3 < 8; f3++)
                for (int a = 0; a < 2; a++) begin
                    in_valid = 1'b1;
                    set_beat(2'(op), 3'(f3), (a == 1) ? 7'h20 : 7'h00, 1'($urandom),
                             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                             TAG_W'($urandom));
                    cycle();
                end
        drain();

        // Operand select
        in_valid = 1'b1;
        set_beat(2'd2, 3'd0, 7'h00, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7FF, 5'd3);
        cycle();
        chk("opsel_rs2_valid", 64'(out_valid), 64'd1);
        chk("opsel_rs2_a", out_a, 64'd5);
        chk("opsel_rs2_b", out_b, 64'hFFFF_FFFF_FFFF_FFFD);
        in_alu_src = 1'b1;
        cycle();
        chk("opsel_imm_a", out_a, 64'd5);
        chk("opsel_imm_b", out_b, 64'h7FF);
        drain();

        // Backpressure: tags 1..6 with the output stalled for 4 cycles
        t         = 1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = (t <= 6);
            set_beat(2'd3, 3'd4, 7'h00, 1'b1, 64'(t), 64'd0, 64'(t * 7), TAG_W'(t));
            pre = (in_ready === 1'b1) && in_valid;
            cycle();
            if (pre) t++;
            chk("bp_stall_tag", 64'(out_tag), 64'd1);
        end
        chk("bp_accepts", 64'(t - 1), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        ncyc      = 0;
        for (int i = 0; i < 20 && got.size() < 6; i++) begin
            if (out_valid === 1'b1) got.push_back(out_tag);
            in_valid = (t <= 6);
            set_beat(2'd3, 3'd4, 7'h00, 1'b1, 64'(t), 64'd0, 64'(t * 7), TAG_W'(t));
            pre = (in_ready === 1'b1) && in_valid;
            cycle();
            if (pre) t++;
            ncyc++;
        end
        chk("bp_count", 64'(got.size()), 64'd6);
        chk("bp_no_gaps", 64'(ncyc), 64'd6);
        foreach (got[i]) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(i + 1));
        drain();

        // Simultaneous transfer and offer while full
        fill(5'd10);
        chk("sim_full_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_beat(2'd2, 3'd7, 7'h00, 1'b0, 64'd55, 64'd66, 64'd0, 5'd12);
        cycle();
        chk("sim_s_to_m_tag", 64'(out_tag), 64'd11);
        chk("sim_in_ready_up", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
        cycle();
        chk("sim_next_accept_tag", 64'(out_tag), 64'd11);
        chk("sim_next_accept_full", 64'(in_ready), 64'd0);
        drain();

        // Flush while full with a beat offered
        fill(5'd13);
        flush    = 1'b1;
        in_valid = 1'b1;
        set_beat(2'd0, 3'd0, 7'h00, 1'b0, 64'd77, 64'd0, 64'd0, 5'd15);
        cycle();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        drain();

        // Reset mid-stall
        fill(5'd16);
        rst_n = 1'b0;
        cycle();
        chk_reset_outputs("rst_mid");
        rst_n    = 1'b1;
        in_valid = 1'b1;
        set_beat(2'd2, 3'd6, 7'h00, 1'b0, 64'd9, 64'd10, 64'd0, 5'd18);
        cycle();
        chk("rst_after_tag", 64'(out_tag), 64'd18);
        chk("rst_after_control", 64'(out_control), 64'd1);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [6:0] f7;
            int sel;
            sel = int'($urandom_range(0, 2));
            f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            set_beat(2'($urandom), 3'($urandom), f7, 1'($urandom),
                     {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                     TAG_W'($urandom));
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
